// File: rtl/ins_enc_pkg.sv
// Shared types and encoding constants for the instruction stream encoder.
// Op classes, RV32I opcode/funct fields, loader FSM states and immediate limits.
package ins_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ADDI = 4'd2,
        OP_SLLI = 4'd3,
        OP_SRLI = 4'd4,
        OP_SRAI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BGE  = 4'd9,
        OP_JALR = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BGE  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

endpackage

// File: rtl/ins_enc_fifo.sv
// Synchronous word FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module ins_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ins_stream_encoder.sv
// Encodes symbolic RV32I-subset ops and streams them into instruction memory.
// Define ENC_IMM_CHECK_EN to reject out-of-range immediates instead of truncating.
module ins_stream_encoder
    import ins_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    input  logic              req_last,
    input  logic              imem_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state;
    logic          s1_valid;
    logic [31:0]   s1_word;
    logic [31:0]   enc_word;
    logic          enc_ok;
    logic          accept;
    logic          drain_done;
    logic [31:0]   fifo_head;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic [AW+1:0] occupancy;
`ifdef ENC_IMM_CHECK_EN
    int            imm_v;
`endif

    // S1 counts toward occupancy so an accepted word always finds room next cycle.
    assign occupancy  = {1'b0, fifo_count} + (AW+2)'(s1_valid);
    assign req_ready  = (state == ST_LOAD) && (occupancy < (AW+2)'(DEPTH));
    assign accept     = req_valid && req_ready;
    assign imem_we    = !fifo_empty && !imem_busy;
    assign imem_wdata = fifo_empty ? '0 : fifo_head;
    assign drain_done = !s1_valid && (fifo_empty || (fifo_count == (AW+1)'(1) && imem_we));

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (req_op)
            OP_ADD:  enc_word = {F7_BASE, req_rs2, req_rs1, F3_ADD, req_rd, OPC_R};
            OP_SUB:  enc_word = {F7_ALT, req_rs2, req_rs1, F3_ADD, req_rd, OPC_R};
            OP_ADDI: enc_word = {req_imm[11:0], req_rs1, F3_ADD, req_rd, OPC_IALU};
            OP_SLLI: enc_word = {F7_BASE, req_imm[4:0], req_rs1, F3_SLL, req_rd, OPC_IALU};
            OP_SRLI: enc_word = {F7_BASE, req_imm[4:0], req_rs1, F3_SRL, req_rd, OPC_IALU};
            OP_SRAI: enc_word = {F7_ALT, req_imm[4:0], req_rs1, F3_SRL, req_rd, OPC_IALU};
            OP_LW:   enc_word = {req_imm[11:0], req_rs1, F3_WORD, req_rd, OPC_LOAD};
            OP_SW:   enc_word = {req_imm[11:5], req_rs2, req_rs1, F3_WORD, req_imm[4:0], OPC_STORE};
            OP_BEQ:  enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, F3_BEQ,
                                 req_imm[4:1], req_imm[11], OPC_BRANCH};
            OP_BGE:  enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, F3_BGE,
                                 req_imm[4:1], req_imm[11], OPC_BRANCH};
            OP_JALR: enc_word = {req_imm[11:0], req_rs1, F3_ADD, req_rd, OPC_JALR};
            default: enc_ok = 1'b0;
        endcase
`ifdef ENC_IMM_CHECK_EN
        imm_v = int'($signed(req_imm));
        case (req_op)
            OP_ADDI, OP_LW, OP_SW, OP_JALR:
                if (imm_v < IMM_I_MIN || imm_v > IMM_I_MAX) enc_ok = 1'b0;
            OP_SLLI, OP_SRLI, OP_SRAI:
                if (imm_v < 0 || imm_v > SHAMT_MAX) enc_ok = 1'b0;
            OP_BEQ, OP_BGE:
                if (imm_v < IMM_B_MIN || imm_v > IMM_B_MAX || req_imm[0]) enc_ok = 1'b0;
            default: ;
        endcase
`endif
    end

    ins_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (s1_word),
        .pop       (imem_we),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            imem_addr <= BASE_ADDR;
            word_cnt  <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_valid <= accept && enc_ok;
            if (accept && enc_ok)  s1_word <= enc_word;
            if (accept && !enc_ok) err     <= 1'b1;
            if (imem_we) begin
                imem_addr <= imem_addr + ADDR_W'(4);
                word_cnt  <= word_cnt + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        imem_addr <= BASE_ADDR;
                        word_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && req_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_stream_encoder.sv
// Directed bench for ins_stream_encoder: a field-arithmetic encoding model feeds an
// expected-write queue that a per-cycle compare process checks against imem writes.
module tb_ins_stream_encoder;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [12:0] req_imm;
    logic        req_last;
    logic        imem_busy;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        done;
    logic        err;
    logic [31:0] word_cnt;

    ins_stream_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .DEPTH     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .imem_busy  (imem_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          model_idx = 0;
    int          last_we_cyc = 0;
    int          sess_acc = 0;
    int          acc_at_stall = -1;
    bit          lat_armed = 1'b0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] got_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    function automatic bit model_legal(input int op, input int imm);
        if (op > 10) return 1'b0;
`ifdef ENC_IMM_CHECK_EN
        if (op == 2 || op == 6 || op == 7 || op == 10) return imm >= -2048 && imm <= 2047;
        if (op >= 3 && op <= 5) return imm >= 0 && imm <= 31;
        if (op == 8 || op == 9) return imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_enc(input int op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input int imm);
        int unsigned u;
        int unsigned regs;
        u    = imm;
        regs = (rd << 7) | (rs1 << 15);
        case (op)
            0:  return 32'h33 | regs | (rs2 << 20);
            1:  return 32'h33 | regs | (rs2 << 20) | (32'h20 << 25);
            2:  return 32'h13 | regs | ((u & 32'hFFF) << 20);
            3:  return 32'h13 | regs | (1 << 12) | ((u & 31) << 20);
            4:  return 32'h13 | regs | (5 << 12) | ((u & 31) << 20);
            5:  return 32'h13 | regs | (5 << 12) | ((u & 31) << 20) | (32'h20 << 25);
            6:  return 32'h03 | regs | (2 << 12) | ((u & 32'hFFF) << 20);
            7:  return 32'h23 | (rs1 << 15) | (rs2 << 20) | (2 << 12)
                       | ((u & 31) << 7) | (((u >> 5) & 127) << 25);
            8, 9: return 32'h63 | (rs1 << 15) | (rs2 << 20) | ((op == 9 ? 5 : 0) << 12)
                       | (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25)
                       | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
            default: return 32'h67 | regs | ((u & 32'hFFF) << 20);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got data 0x%0h at 0x%0h, expected no write",
                         imem_wdata, imem_addr);
            end else begin
                chk("wdata", imem_wdata, exp_q.pop_front());
                chk("waddr", imem_addr, BASE + 32'(4 * model_idx));
                if (acc_q.size() > 0) begin
                    if (lat_armed) chk("accept_to_write_latency", cyc - acc_q[0], 1);
                    void'(acc_q.pop_front());
                end
            end
            model_idx++;
            got_words.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (!rst && done) begin
            chk("done_with_we", imem_we, 0);
            if (model_idx > 0) chk("done_after_last_write", cyc - last_we_cyc, 1);
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        model_idx = 0;
        sess_acc = 0;
        acc_at_stall = -1;
        exp_q.delete();
        acc_q.delete();
        got_words.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input bit last);
        int waited;
        waited    = 0;
        req_op    = 4'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = 13'(imm);
        req_last  = last;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            if (acc_at_stall < 0) acc_at_stall = sess_acc;
            waited++;
            if (waited > 200) begin
                fail_now("req_ready_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        sess_acc++;
        if (model_legal(op, imm)) begin
            exp_q.push_back(model_enc(op, rd, rs1, rs2, imm));
            acc_q.push_back(cyc);
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        fail_now("done_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0; imem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_ready_idle", req_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, BASE);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        req_valid = 1'b0;

        // ADD / SUB pair
        lat_armed = 1'b1;
        do_start();
        send(0, 3, 1, 2, 0, 0);
        send(1, 3, 1, 2, 0, 1);
        wait_done(50);
        chk("t1_word0", got_words[0], 32'h002081B3);
        chk("t1_word1", got_words[1], 32'h402081B3);
        chk("t1_word_cnt", word_cnt, 2);
        chk("t1_queue_drained", exp_q.size(), 0);

        // ADDI / LW / JALR, with a stray start during LOAD that must be ignored
        do_start();
        send(2, 5, 0, 0, -1, 0);
        start = 1'b1;
        send(6, 6, 2, 0, 8, 0);
        start = 1'b0;
        send(10, 0, 1, 0, 0, 1);
        wait_done(50);
        chk("t2_word0", got_words[0], 32'hFFF00293);
        chk("t2_word1", got_words[1], 32'h00812303);
        chk("t2_word2", got_words[2], 32'h00008067);
        chk("t2_word_cnt", word_cnt, 3);

        // branches plus legal immediate extremes
        do_start();
        send(8, 0, 1, 2, -4, 0);
        send(9, 0, 1, 2, -4, 0);
        send(3, 1, 1, 0, 31, 0);
        send(7, 0, 3, 2, -2048, 0);
        send(5, 4, 4, 0, 7, 0);
        send(9, 0, 7, 9, 4094, 1);
        wait_done(50);
        chk("t3_beq", got_words[0], 32'hFE208EE3);
        chk("t3_bge", got_words[1], 32'hFE20DEE3);
        chk("t3_word_cnt", word_cnt, 6);
        chk("t3_err", err, 0);

        // back-pressure: imem_busy high for 10 cycles under a 6-request stream
        lat_armed = 1'b0;
        do_start();
        fork
            begin
                imem_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                imem_busy = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) send(2, i + 1, 0, 0, i * 7 + 1, i == 5);
            end
        join
        wait_done(80);
        chk("t4_accepted_before_stall", acc_at_stall, 4);
        chk("t4_word_cnt", word_cnt, 6);
        chk("t4_queue_drained", exp_q.size(), 0);

        // illegal op, then an out-of-range ADDI
        do_start();
        send(12, 1, 1, 1, 0, 0);
        send(2, 1, 0, 0, 3000, 1);
        wait_done(50);
        chk("t5_err", err, 1);
`ifdef ENC_IMM_CHECK_EN
        chk("t5_word_cnt", word_cnt, 0);
`else
        chk("t5_word_cnt", word_cnt, 1);
        chk("t5_addi_trunc", got_words[0], 32'hBB800093);
`endif

        // reset mid-session with three words buffered
        do_start();
        imem_busy = 1'b1;
        send(13, 0, 0, 0, 0, 0);
        send(2, 1, 0, 0, 1, 0);
        send(2, 2, 0, 0, 2, 0);
        send(2, 3, 0, 0, 3, 0);
        @(posedge clk);
        #1;
        chk("t6_err_before_rst", err, 1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_busy = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        chk("t6_we_after_rst", imem_we, 0);
        chk("t6_err_after_rst", err, 0);
        chk("t6_ready_after_rst", req_ready, 0);
        chk("t6_word_cnt_after_rst", word_cnt, 0);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        do_start();
        send(0, 9, 8, 7, 0, 1);
        wait_done(50);
        chk("t6_restart_word", got_words[0], 32'h007404B3);
        chk("t6_restart_cnt", word_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
